latch_edge_monitor: RTL and testbench
=====================================

# latch_edge_monitor

- Downstream consumer of the D-latch output `q`.
- Brings the asynchronous latch output into the `clk` domain through a two-flop synchronizer.
- Debounces it with a cycle-count filter and emits one-cycle rise/fall pulses.
- Maintains saturating rise and fall event counters with a sticky overflow flag, so software/bench logic can audit latch transparency activity.

## Interface

Parameters:
- `CNT_WIDTH`, default 8: width of each event counter.
- `DEBOUNCE`, default 3: consecutive synchronized samples (legal range 1..15) that must disagree with the filtered level before it flips.

Ports:
- `clk`  input  1  system clock, all state on rising edge.
- `reset`  input  1  asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `q_in`  input  1  latch output `q`; asynchronous to `clk`.
- `clear`  input  1  synchronous clear of counters and overflow flag.
- `level`  output  1  debounced, synchronized level of `q_in`.
- `rise_pulse`  output  1  one-cycle strobe when `level` goes 0→1.
- `fall_pulse`  output  1  one-cycle strobe when `level` goes 1→0.
- `rise_count`  output  `CNT_WIDTH`  number of rises, saturating.
- `fall_count`  output  `CNT_WIDTH`  number of falls, saturating.
- `overflow`  output  1  sticky; set when either counter attempts to pass all-ones.

## Operation

- **Synchronizer:** `q_in` → ff1 → ff2. The output `s` is the only signal used downstream.
- **Filter:** a 4-bit `db_cnt` and a four-state FSM.
  - `LOW`: `level=0`. When `s=1`, go to `PEND_H` with `db_cnt=1`.
  - `PEND_H`:
    - `s=0` → back to `LOW`, `db_cnt=0`.
    - `s=1` and `db_cnt==DEBOUNCE-1` → `HIGH`, `level←1`, `rise_pulse←1`, `db_cnt=0`.
    - Otherwise `db_cnt++`.
  - `HIGH` and `PEND_L` mirror `LOW` and `PEND_H`, asserting `fall_pulse`.
  - With `DEBOUNCE=1`: `LOW`→`HIGH` directly on the first `s=1` sample. The pending states are skipped.
- **Pulses:** registered, high for exactly one cycle, never both high in the same cycle.
- **Counters:**
  - `rise_count` increments on the same edge that sets `rise_pulse`; `fall_count` likewise on `fall_pulse`.
  - At all-ones a counter holds its value and `overflow←1`.
- **`clear`:** zeroes both counters and `overflow` on the next edge. It does not affect `level`, the FSM, the synchronizer or the pulses.
  - `clear` wins over a simultaneous increment: the count becomes 0, not 1, and that event is lost.
- **Reset:** all outputs 0, FSM=`LOW`, `db_cnt=0`, sync flops 0.
  - If `q_in` is already high when reset releases, a normal debounced rise is reported and counted.
  - Reset asserted mid-pending discards the pending transition.

## Timing

- **Latency:** `q_in` stable before edge E1 → `s` valid after E2 → `level`/pulse/count update at edge E(2+DEBOUNCE). With the default this is E5.
- **Glitch rejection:** any `s` pulse shorter than `DEBOUNCE` samples produces no `level` change and no count.
- **Minimum event spacing:** back-to-back opposite transitions need ≥`DEBOUNCE` cycles each.
- **Outputs:** all registered; no combinational path from any input to any output.

## Structure

- **Shared package `latch_mon_pkg`:**
  - FSM state typedef `{LOW, PEND_H, HIGH, PEND_L}`, 2-bit encoding.
  - Localparam `DB_W=4`.
- **Sub-module `sync_2ff`:** 1-bit two-flop synchronizer with the same `clk`/`reset`, reset value 0. Reused elsewhere for other async inputs.
- **Top:** FSM, debounce counter, two saturating counters and the overflow flag.

## Test plan

- **Reset:** hold `reset=1` with `q_in=1`, release → all outputs 0 immediately; `level=1`, `rise_pulse` for one cycle and `rise_count=1` at the 5th edge after release.
- **Clean toggle (`DEBOUNCE=3`):** `q_in` 0→1, then 1→0 held 10 cycles each → `rise_count=1`, `fall_count=1`, each pulse exactly one cycle wide, 5 edges after the corresponding input change.
- **Glitch:** `q_in` high for 2 clock periods, then low → `level` stays 0, no pulses, counts unchanged. Repeat with a 3-period pulse → one rise and one fall counted.
- **Saturation (`CNT_WIDTH=2`):** 5 clean rise/fall pairs → `rise_count=3`, `fall_count=3`, `overflow=1` after the 4th rise. Then pulse `clear` → counts 0, `overflow=0`, `level` unchanged.
- **Clear collision:** assert `clear` in the same cycle the 3rd rise registers → `rise_count=0` after that edge, next rise gives 1.
- **Async reset mid-pending:** assert `reset` while in `PEND_H` with `db_cnt=2` → outputs 0 asynchronously, without waiting for a clock edge. After release with `q_in=0`, no rise is reported.

Source files
------------

// File: rtl/latch_mon_pkg.sv
// Shared types and constants for the latch edge monitor.
// Holds the debounce FSM state encoding and the debounce counter width.
package latch_mon_pkg;

  localparam int DB_W = 4;

  typedef enum logic [1:0] {
    LOW    = 2'd0,
    PEND_H = 2'd1,
    HIGH   = 2'd2,
    PEND_L = 2'd3
  } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer for an asynchronous input.
// Used here for the latch output and intended for reuse on other async inputs.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic r_meta;

  // NOTE: non-blocking assignments let both flops sample on the same edge, so
  // d really takes two clocks to reach q; blocking here would collapse the chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= 1'b0;
      q      <= 1'b0;
    end else begin
      r_meta <= d;
      q      <= r_meta;
    end
  end

endmodule

// File: rtl/latch_edge_monitor.sv
// Synchronizes and debounces a D-latch output, emitting rise/fall strobes and
// keeping saturating event counters with a sticky overflow flag.
module latch_edge_monitor
  import latch_mon_pkg::*;
#(
  parameter int CNT_WIDTH = 8,
  parameter int DEBOUNCE  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 q_in,
  input  logic                 clear,
  output logic                 level,
  output logic                 rise_pulse,
  output logic                 fall_pulse,
  output logic [CNT_WIDTH-1:0] rise_count,
  output logic [CNT_WIDTH-1:0] fall_count,
  output logic                 overflow
);

  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE - 1);
  localparam bit              SKIP_PEND = (DEBOUNCE == 1);

  logic            w_s;
  logic            w_rise;
  logic            w_fall;
  state_e          r_state;
  logic [DB_W-1:0] r_db_cnt;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (q_in),
    .q     (w_s)
  );

  // An event fires on the sample that completes DEBOUNCE consecutive disagreeing
  // samples; with DEBOUNCE=1 that is the very first one seen from a settled state.
  always_comb begin
    w_rise = 1'b0;
    w_fall = 1'b0;
    case (r_state)
      LOW:    w_rise = w_s && SKIP_PEND;
      PEND_H: w_rise = w_s && (r_db_cnt == DB_LAST);
      HIGH:   w_fall = !w_s && SKIP_PEND;
      PEND_L: w_fall = !w_s && (r_db_cnt == DB_LAST);
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= LOW;
      r_db_cnt   <= '0;
      level      <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= w_rise;
      fall_pulse <= w_fall;
      case (r_state)
        LOW: begin
          if (w_rise) begin
            r_state <= HIGH;
            level   <= 1'b1;
          end else if (w_s) begin
            r_state  <= PEND_H;
            r_db_cnt <= DB_W'(1);
          end
        end
        PEND_H: begin
          if (!w_s) begin
            r_state  <= LOW;
            r_db_cnt <= '0;
          end else if (w_rise) begin
            r_state  <= HIGH;
            level    <= 1'b1;
            r_db_cnt <= '0;
          end else begin
            r_db_cnt <= r_db_cnt + DB_W'(1);
          end
        end
        HIGH: begin
          if (w_fall) begin
            r_state <= LOW;
            level   <= 1'b0;
          end else if (!w_s) begin
            r_state  <= PEND_L;
            r_db_cnt <= DB_W'(1);
          end
        end
        PEND_L: begin
          if (w_s) begin
            r_state  <= HIGH;
            r_db_cnt <= '0;
          end else if (w_fall) begin
            r_state  <= LOW;
            level    <= 1'b0;
            r_db_cnt <= '0;
          end else begin
            r_db_cnt <= r_db_cnt + DB_W'(1);
          end
        end
        default: r_state <= LOW;
      endcase
    end
  end

  // Clear takes priority over a coincident event, which is then dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rise_count <= '0;
      fall_count <= '0;
      overflow   <= 1'b0;
    end else if (clear) begin
      rise_count <= '0;
      fall_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (w_rise) begin
        if (&rise_count) overflow <= 1'b1;
        else             rise_count <= rise_count + CNT_WIDTH'(1);
      end
      if (w_fall) begin
        if (&fall_count) overflow <= 1'b1;
        else             fall_count <= fall_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_latch_edge_monitor.sv
// Self-checking bench for latch_edge_monitor: directed test-plan steps followed by
// random q_in runs, all checked every cycle against a sliding-window reference model.
module tb_latch_edge_monitor;

  localparam int CNT_W = 2;
  localparam int DB    = 3;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             q_in;
  logic             clear;
  logic             level;
  logic             rise_pulse;
  logic             fall_pulse;
  logic [CNT_W-1:0] rise_count;
  logic [CNT_W-1:0] fall_count;
  logic             overflow;

  int    total = 0;
  int    bad   = 0;
  string phase = "init";

  // Reference model: synchronizer as two delay stages, filter as "last DB samples
  // all disagree with the current level", counters as clamped integers.
  logic m_q1, m_s, m_lvl, m_rp, m_fp, m_ovf;
  int   m_rc, m_fc;
  logic hist[$];

  latch_edge_monitor #(.CNT_WIDTH(CNT_W), .DEBOUNCE(DB)) dut (
    .clk        (clk),
    .reset      (reset),
    .q_in       (q_in),
    .clear      (clear),
    .level      (level),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .rise_count (rise_count),
    .fall_count (fall_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q1 = 1'b0; m_s = 1'b0; m_lvl = 1'b0; m_rp = 1'b0; m_fp = 1'b0;
    m_ovf = 1'b0; m_rc = 0; m_fc = 0;
    hist.delete();
  endtask

  task automatic model_edge(input logic qv, input logic cv);
    logic flip;
    m_rp = 1'b0;
    m_fp = 1'b0;
    hist.push_back(m_s);
    if (hist.size() > DB) void'(hist.pop_front());
    flip = (hist.size() == DB);
    foreach (hist[i]) if (hist[i] == m_lvl) flip = 1'b0;
    if (flip) begin
      m_lvl = ~m_lvl;
      if (m_lvl) m_rp = 1'b1;
      else       m_fp = 1'b1;
    end
    if (cv) begin
      m_rc = 0; m_fc = 0; m_ovf = 1'b0;
    end else begin
      if (m_rp) begin if (m_rc == CMAX) m_ovf = 1'b1; else m_rc++; end
      if (m_fp) begin if (m_fc == CMAX) m_ovf = 1'b1; else m_fc++; end
    end
    m_s  = m_q1;
    m_q1 = qv;
  endtask

  task automatic check_all();
    chk({phase, ".level"},      32'(level),      32'(m_lvl));
    chk({phase, ".rise_pulse"}, 32'(rise_pulse), 32'(m_rp));
    chk({phase, ".fall_pulse"}, 32'(fall_pulse), 32'(m_fp));
    chk({phase, ".rise_count"}, 32'(rise_count), 32'(m_rc));
    chk({phase, ".fall_count"}, 32'(fall_count), 32'(m_fc));
    chk({phase, ".overflow"},   32'(overflow),   32'(m_ovf));
  endtask

  task automatic tick(input logic qv, input logic cv = 1'b0);
    q_in  = qv;
    clear = cv;
    @(posedge clk);
    if (reset) model_reset();
    else       model_edge(qv, cv);
    #1;
    check_all();
  endtask

  task automatic pair(input int n);
    repeat (n) tick(1'b1);
    repeat (n) tick(1'b0);
  endtask

  initial begin
    int run_len;
    logic run_val;

    // Reset held with q_in already high: a normal debounced rise follows release.
    phase = "reset";
    reset = 1'b1; q_in = 1'b1; clear = 1'b0;
    model_reset();
    repeat (3) tick(1'b1);
    reset = 1'b0;
    #1;
    check_all();
    repeat (4) tick(1'b1);
    chk("reset.level_e4", 32'(level), 0);
    tick(1'b1);
    chk("reset.level_e5", 32'(level), 1);
    chk("reset.rise_e5", 32'(rise_pulse), 1);
    chk("reset.count_e5", 32'(rise_count), 1);
    tick(1'b1);
    chk("reset.rise_e6", 32'(rise_pulse), 0);
    repeat (4) tick(1'b1);

    // Clean toggles: each strobe lands on the 5th edge after the input change.
    phase = "toggle";
    repeat (4) tick(1'b0);
    chk("toggle.fall_e4", 32'(fall_pulse), 0);
    tick(1'b0);
    chk("toggle.fall_e5", 32'(fall_pulse), 1);
    tick(1'b0);
    chk("toggle.fall_e6", 32'(fall_pulse), 0);
    repeat (4) tick(1'b0);
    repeat (4) tick(1'b1);
    chk("toggle.rise_e4", 32'(rise_pulse), 0);
    tick(1'b1);
    chk("toggle.rise_e5", 32'(rise_pulse), 1);
    repeat (5) tick(1'b1);
    repeat (10) tick(1'b0);
    chk("toggle.rise_count", 32'(rise_count), 2);
    chk("toggle.fall_count", 32'(fall_count), 2);

    // Glitches: two samples rejected, three samples accepted.
    phase = "glitch";
    repeat (2) tick(1'b1);
    repeat (8) tick(1'b0);
    chk("glitch2.rise_count", 32'(rise_count), 2);
    chk("glitch2.fall_count", 32'(fall_count), 2);
    repeat (3) tick(1'b1);
    repeat (8) tick(1'b0);
    chk("glitch3.rise_count", 32'(rise_count), 3);
    chk("glitch3.fall_count", 32'(fall_count), 3);

    // Saturation of the 2-bit counters and the sticky overflow flag.
    phase = "sat";
    tick(1'b0, 1'b1);
    for (int p = 1; p <= 5; p++) begin
      pair(6);
      chk("sat.rise_count", 32'(rise_count), (p < 3) ? p : 3);
      chk("sat.fall_count", 32'(fall_count), (p < 3) ? p : 3);
      chk("sat.overflow", 32'(overflow), (p >= 4) ? 1 : 0);
    end
    tick(1'b0, 1'b1);
    chk("sat.clr_rise", 32'(rise_count), 0);
    chk("sat.clr_fall", 32'(fall_count), 0);
    chk("sat.clr_ovf", 32'(overflow), 0);
    chk("sat.clr_level", 32'(level), 0);

    // Clear landing on the same edge as the 3rd rise.
    phase = "collide";
    pair(6);
    pair(6);
    repeat (4) tick(1'b1);
    tick(1'b1, 1'b1);
    chk("collide.pulse", 32'(rise_pulse), 1);
    chk("collide.rise_count", 32'(rise_count), 0);
    repeat (6) tick(1'b0);
    repeat (6) tick(1'b1);
    chk("collide.next_rise", 32'(rise_count), 1);
    repeat (8) tick(1'b0);

    // Asynchronous reset while a rise is pending with two samples seen.
    phase = "midpend";
    repeat (4) tick(1'b1);
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("midpend.async_level", 32'(level), 0);
    chk("midpend.async_rise_count", 32'(rise_count), 0);
    chk("midpend.async_fall_count", 32'(fall_count), 0);
    check_all();
    repeat (2) tick(1'b0);
    reset = 1'b0;
    repeat (8) tick(1'b0);
    chk("midpend.no_rise_level", 32'(level), 0);
    chk("midpend.no_rise_count", 32'(rise_count), 0);

    // Random runs of q_in with occasional clears.
    phase = "random";
    run_val = 1'b0;
    for (int n = 0; n < 120; n++) begin
      run_val = ~run_val;
      run_len = $urandom_range(1, 7);
      repeat (run_len) tick(run_val, ($urandom_range(0, 19) == 0));
    end
    repeat (8) tick(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
